// File: rtl/gpio_event_master.sv
// Avalon-MM initiator servicing an edge-capture GPIO slave: programs irq_mask, then on irq
// reads and clears edge_capture and emits the edges as a valid/ready event.
// Optional macro GPIO_EVT_LEVEL_EN adds an input-level read (RDL) that fills evt_level.
module gpio_event_master #(
    parameter int unsigned      WIDTH        = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK     = WIDTH'(4'hF),
    parameter int unsigned      READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             irq,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic             busy
);

    localparam int unsigned      CNT_W     = 2;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [1:0]       ADDR_DATA = 2'd0;
    localparam logic [1:0]       ADDR_MASK = 2'd2;
    localparam logic [1:0]       ADDR_EDGE = 2'd3;

    // S_INIT is the idle-bus cycle after reset; the mask write itself is S_INIT_WR.
    typedef enum logic [3:0] {
        S_INIT, S_INIT_WR, S_IDLE, S_RD, S_WAIT, S_CLR, S_RDL, S_WAITL, S_PUSH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [WIDTH-1:0] edge_reg;

    logic unused_rdata_bits;
    assign unused_rdata_bits = ^avm_readdata[31:WIDTH];

`ifndef GPIO_EVT_LEVEL_EN
    assign evt_level = '0;
`endif

    // Bus outputs are registered for the state being entered, so each access
    // is on the bus exactly during its own state cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_INIT;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            evt_valid      <= 1'b0;
            evt_edges      <= '0;
            busy           <= 1'b1;
            wait_cnt       <= '0;
            edge_reg       <= '0;
`ifdef GPIO_EVT_LEVEL_EN
            evt_level      <= '0;
`endif
        end else begin
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;

            case (state)
                S_INIT: begin
                    state          <= S_INIT_WR;
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= ADDR_MASK;
                    avm_writedata  <= 32'(IRQ_MASK);
                end
                S_INIT_WR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_IDLE: begin
                    if (irq) begin
                        state          <= S_RD;
                        busy           <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_EDGE;
                    end
                end
                S_RD: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        edge_reg       <= avm_readdata[WIDTH-1:0] & IRQ_MASK;
                        state          <= S_CLR;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= ADDR_EDGE;
                    end else begin
                        wait_cnt <= CNT_W'(wait_cnt + 1'b1);
                    end
                end
                S_CLR: begin
                    // A zero capture means a spurious irq: return without an event.
                    if (edge_reg != '0) begin
`ifdef GPIO_EVT_LEVEL_EN
                        state          <= S_RDL;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_DATA;
`else
                        state     <= S_PUSH;
                        evt_valid <= 1'b1;
                        evt_edges <= edge_reg;
`endif
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef GPIO_EVT_LEVEL_EN
                S_RDL: begin
                    state    <= S_WAITL;
                    wait_cnt <= '0;
                end
                S_WAITL: begin
                    if (wait_cnt == LAST_WAIT) begin
                        evt_level <= avm_readdata[WIDTH-1:0];
                        state     <= S_PUSH;
                        evt_valid <= 1'b1;
                        evt_edges <= edge_reg;
                    end else begin
                        wait_cnt <= CNT_W'(wait_cnt + 1'b1);
                    end
                end
`endif
                S_PUSH: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_event_master.sv
// Scoreboard bench for gpio_event_master with a behavioural edge-capture PIO slave
// (read latency 1); honours GPIO_EVT_LEVEL_EN.
`timescale 1ns/1ps
module tb_gpio_event_master;

    localparam int unsigned WIDTH = 4;
`ifdef GPIO_EVT_LEVEL_EN
    localparam bit LEVEL_EN = 1'b1;
    localparam int EVT_LAT  = 6;
`else
    localparam bit LEVEL_EN = 1'b0;
    localparam int EVT_LAT  = 4;
`endif

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } bus_t;

    typedef struct packed {
        logic [WIDTH-1:0] edges;
        logic [WIDTH-1:0] level;
    } evt_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             slave_rst_n;
    logic             irq;
    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata;
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_edges;
    logic [WIDTH-1:0] evt_level;
    logic             busy;

    logic [WIDTH-1:0] in_port;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] slv_mask;
    logic             force_irq;

    bus_t bus_q[$];
    evt_t evt_q[$];
    int   rd_cycs[$];
    int   accept_cycs[$];
    int   last_clr_cyc = 0;
    int   valid_cycles = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpio_event_master #(
        .WIDTH(WIDTH), .IRQ_MASK(4'hF), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .irq(irq),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_edges(evt_edges), .evt_level(evt_level), .busy(busy)
    );

    // Behavioural PIO slave: rising-edge capture, clear-on-write has priority.
    assign irq = (|(edge_cap & slv_mask)) | force_irq;

    always @(posedge clk or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            in_prev      <= '0;
            edge_cap     <= '0;
            slv_mask     <= '0;
            avm_readdata <= '0;
        end else begin
            in_prev <= in_port;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
                edge_cap <= '0;
            else
                edge_cap <= edge_cap | (in_port & ~in_prev);
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
                slv_mask <= avm_writedata[WIDTH-1:0];
            avm_readdata <= '0;
            if (avm_chipselect && avm_write_n) begin
                case (avm_address)
                    2'd0:    avm_readdata <= 32'(in_port);
                    2'd2:    avm_readdata <= 32'(slv_mask);
                    2'd3:    avm_readdata <= 32'(edge_cap);
                    default: avm_readdata <= '0;
                endcase
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bus(input logic wr, input logic [1:0] addr, input logic [31:0] data);
        bus_t b;
        b.wr = wr; b.addr = addr; b.data = data;
        bus_q.push_back(b);
    endtask

    task automatic push_irq_bus(input bit with_event);
        push_bus(1'b0, 2'd3, 32'h0);
        push_bus(1'b1, 2'd3, 32'h0);
        if (with_event && LEVEL_EN) push_bus(1'b0, 2'd0, 32'h0);
    endtask

    task automatic push_evt(input logic [WIDTH-1:0] edges, input logic [WIDTH-1:0] level);
        evt_t e;
        e.edges = edges;
        e.level = LEVEL_EN ? level : '0;
        evt_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // sel: 0 irq high, 1 evt_valid high, 2 everything drained and idle
    task automatic wait_cond(input int sel, input int max_cyc, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = irq;
                1:       hit = evt_valid;
                default: hit = !busy && bus_q.size() == 0 && evt_q.size() == 0;
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles", name, max_cyc);
        end
    endtask

    // Bus monitor: every access must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_chipselect) begin
                if (avm_write_n && avm_address == 2'd3) rd_cycs.push_back(cyc);
                if (!avm_write_n && avm_address == 2'd3) last_clr_cyc = cyc;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got write_n=%0b addr=%0d expected no access (cycle %0d)",
                             avm_write_n, avm_address, cyc);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("bus_write_n", 32'(avm_write_n), 32'(!b.wr));
                    chk("bus_addr", 32'(avm_address), 32'(b.addr));
                    if (b.wr) chk("bus_wdata", avm_writedata, b.data);
                end
            end else begin
                chk("bus_idle", 32'({avm_write_n, avm_address}), 32'(3'b100));
            end
        end
    end

    // Event monitor: payload checked every valid cycle (stability), popped on handshake.
    always @(negedge clk) begin
        if (reset_n && evt_valid) begin
            valid_cycles++;
            if (evt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_unexpected: got edges=0x%0h expected no event (cycle %0d)", evt_edges, cyc);
            end else begin
                chk("evt_edges", 32'(evt_edges), 32'(evt_q[0].edges));
                chk("evt_level", 32'(evt_level), 32'(evt_q[0].level));
                if (evt_ready) begin
                    void'(evt_q.pop_front());
                    accept_cycs.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, v, na, nr, vc;
        reset_n = 1'b0; slave_rst_n = 1'b0;
        in_port = '0; evt_ready = 1'b0; force_irq = 1'b0;
        repeat (2) step();

        // reset values
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_write_n", 32'(avm_write_n), 32'd1);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_edges", 32'(evt_edges), 32'd0);
        chk("rst_level", 32'(evt_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // init: single mask write, then quiet
        push_bus(1'b1, 2'd2, 32'h0000_000F);
        slave_rst_n = 1'b1;
        reset_n = 1'b1;
        wait_cond(2, 20, "init_done");
        repeat (5) step();
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_slave_mask", 32'(slv_mask), 32'hF);

        // edge on bit 1, then stall the consumer for 10 cycles
        push_irq_bus(1'b1);
        push_evt(4'b0010, 4'b0010);
        in_port = 4'b0010;
        wait_cond(0, 10, "irq1_rise");
        c0 = cyc;
        wait_cond(1, 20, "evt1_valid");
        v = cyc;
        chk("evt1_latency", 32'(v - c0), 32'(EVT_LAT));
        chk("rd1_cycle", 32'(rd_cycs[0] - c0), 32'd1);
        chk("clr1_cycle", 32'(last_clr_cyc - c0), 32'd3);
        chk("irq_low_at_evt", 32'(irq), 32'd0);

        na = accept_cycs.size();
        nr = rd_cycs.size();
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 3) begin
                in_port = 4'b1010;
                push_irq_bus(1'b1);
                push_evt(4'b1000, 4'b1010);
            end
        end
        chk("stall_valid", 32'(evt_valid), 32'd1);
        chk("stall_no_accept", 32'(accept_cycs.size() - na), 32'd0);
        evt_ready = 1'b1;
        wait_cond(2, 40, "evt2_drain");
        chk("accept_after_stall", 32'(accept_cycs[na] - v), 32'd10);
        chk("rd_after_accept", 32'(rd_cycs[nr] - accept_cycs[na]), 32'd2);
        chk("two_events", 32'(accept_cycs.size() - na), 32'd2);

        // spurious irq: read + clear, no event
        vc = valid_cycles;
        push_irq_bus(1'b0);
        step();
        force_irq = 1'b1;
        step();
        force_irq = 1'b0;
        wait_cond(2, 20, "spurious_done");
        repeat (3) step();
        chk("spurious_no_evt", 32'(valid_cycles - vc), 32'd0);
        chk("spurious_clr_gap", 32'(last_clr_cyc - rd_cycs[rd_cycs.size()-1]), 32'd2);

        // reset pulse during WAIT: async return to reset values, init repeats,
        // and the still-captured edge is serviced afterwards
        na = accept_cycs.size();
        push_bus(1'b0, 2'd3, 32'h0);
        step();
        in_port = 4'b1011;
        wait_cond(0, 10, "irq3_rise");
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_cs", 32'(avm_chipselect), 32'd0);
        chk("arst_write_n", 32'(avm_write_n), 32'd1);
        chk("arst_addr", 32'(avm_address), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_valid", 32'(evt_valid), 32'd0);
        chk("arst_rd_consumed", 32'(bus_q.size()), 32'd0);
        bus_q.delete();
        push_bus(1'b1, 2'd2, 32'h0000_000F);
        push_irq_bus(1'b1);
        push_evt(4'b0001, 4'b1011);
        repeat (2) step();
        reset_n = 1'b1;
        wait_cond(2, 40, "reset_recover");
        chk("recover_event", 32'(accept_cycs.size() - na), 32'd1);

        repeat (3) step();
        chk("queues_empty", 32'(bus_q.size() + evt_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
